mat_mul_mnk: RTL and testbench
==============================

Name: mat_mul_mnk

Overview:
Parametrised fixed-point matrix multiplier computing C = A·B, where A is M×K, B is K×N and C is M×N. It is the generalised successor of the fixed 4×4 multiplier in the transform pipeline. It adds configurable dimensions, round-to-nearest, a full-width accumulator, and a two-sided valid/ready handshake with output hold. It uses one K-step MAC pass with M×N parallel multipliers.

Parameters:
DATAWIDTH, 18, signed word width of A, B and C (two's complement).
FRACBITS, 12, fractional bits of every operand and result (default Q6.12).
M, 4, rows of A and C (≥1).
K, 4, columns of A / rows of B, equal to the number of accumulate cycles (≥1).
N, 4, columns of B and C (≥1).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
A  input  signed [DATAWIDTH-1:0] [M][K]  left operand.
B  input  signed [DATAWIDTH-1:0] [K][N]  right operand.
i_dv  input  1  input valid.
o_ready  output  1  block can accept an input.
C  output  signed [DATAWIDTH-1:0] [M][N]  result, registered.
o_dv  output  1  result valid.
i_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, o_ready=1, o_dv=0, all C=0, accumulators=0, index=0.
- Reset asserted mid-operation aborts immediately with the same values. The in-flight result is discarded.
- Accumulator width ACCW = 2*DATAWIDTH + clog2(K) + 1, signed. Products are full 2*DATAWIDTH-bit signed values, sign-extended into the accumulator.
- States:
  - IDLE: o_ready=1. On an edge with i_dv=1, latch A and B, clear all accumulators, set index=0, and go to ACCUM. While o_ready=0, i_dv is ignored.
  - ACCUM: on each edge, acc[i][j] += A_r[i][index]*B_r[index][j] for all i,j, and index++. After the edge that processes index=K-1, go to OUT. The output register loads at the transition into OUT.
  - OUT: o_dv=1 and C is held stable. On an edge with i_ready=1, set o_dv=0 and return to IDLE, where o_ready=1 again. If i_ready stays 0, hold indefinitely.
- o_ready=1 only in IDLE.
- Latency: the acceptance edge is t0. C and o_dv=1 become visible after edge t0+K. The minimum throughput is one result per K+2 cycles.
- Output conversion, applied per element:
  - r = (acc + 2^(FRACBITS-1)) >>> FRACBITS, i.e. arithmetic shift with round-half-toward-+inf.
  - When FRACBITS=0, no rounding term is added.
  - The narrowing of r to DATAWIDTH is set by the optional feature.
- index counter width is max(1, clog2(K)). It must not wrap before K-1 when K is a power of two.
- o_ready, o_dv and C are all driven from flops; there are no combinational input-to-output paths.

Optional Feature:
Macro MAT_MUL_SAT_EN.
- Defined: r is saturated to [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1] before it is stored in C.
- Undefined: C takes the low DATAWIDTH bits of r (two's-complement wrap), with no saturation logic.
- The macro has no effect on timing or handshake.

Test Plan:
1. Identity: defaults, A = I (diagonal 4096, i.e. 1.0), B[i][j] = 4096*(i*4+j) - 30000 (all values in range). Expected: C == B exactly; o_dv rises 4 cycles after the acceptance edge.
2. Rounding: A[0][0]=1, B[0][0]=2048, all other elements 0. Expected: C[0][0]=1. Then A[0][0]=-1 with the same B. Expected: C[0][0]=0.
3. Overflow: A[0][0]=B[0][0]=81920 (20.0), all other elements 0. Expected: C[0][0]=131071 with MAT_MUL_SAT_EN defined, and 65536 (16.0, wrap) without it.
4. Backpressure: hold i_ready=0 for 5 cycles after o_dv rises, and pulse i_dv with new data during that time. Expected: C and o_dv stay stable; o_ready stays 0; the new input is ignored. Then raise i_ready. Expected: o_dv=0 and o_ready=1 on the next edge.
5. Reset mid-op: assert rst 2 cycles into ACCUM. Expected: immediately o_dv=0, o_ready=1, C all 0. After releasing rst, a fresh identity run produces the correct result.
6. Non-square: M=2, K=3, N=1, A=[[1.0,2.0,3.0],[-1.0,0.5,0.25]], B=[1.0,1.0,1.0]. Expected: C=[24576, -1024] (6.0, -0.25); o_dv visible after edge t0+3.

Source files
------------

// File: rtl/mat_mul_mnk.sv
// Fixed-point C = A*B (MxK by KxN) using M*N parallel MACs over K cycles, with a valid/ready handshake.
// Optional macro MAT_MUL_SAT_EN saturates results to DATAWIDTH; otherwise results wrap.
module mat_mul_mnk #(
    parameter int DATAWIDTH = 18,
    parameter int FRACBITS  = 12,
    parameter int M         = 4,
    parameter int K         = 4,
    parameter int N         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATAWIDTH-1:0] A [M][K],
    input  logic signed [DATAWIDTH-1:0] B [K][N],
    input  logic                        i_dv,
    output logic                        o_ready,
    output logic signed [DATAWIDTH-1:0] C [M][N],
    output logic                        o_dv,
    input  logic                        i_ready
);

    localparam int PW   = 2 * DATAWIDTH;
    localparam int ACCW = PW + $clog2(K) + 1;
    localparam int IW   = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic signed [ACCW-1:0] RND =
        (FRACBITS > 0) ? (ACCW'(1) << ((FRACBITS > 0) ? FRACBITS - 1 : 0)) : '0;
    localparam logic signed [ACCW-1:0] SAT_MAX =
        {{(ACCW - DATAWIDTH + 1){1'b0}}, {(DATAWIDTH - 1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN =
        {{(ACCW - DATAWIDTH + 1){1'b1}}, {(DATAWIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t                        state;
    logic          [IW-1:0]        idx;
    logic signed   [DATAWIDTH-1:0] a_r      [M][K];
    logic signed   [DATAWIDTH-1:0] b_r      [K][N];
    logic signed   [ACCW-1:0]      acc      [M][N];
    logic signed   [ACCW-1:0]      acc_next [M][N];

    // One MAC step per element: the product for the current index added into the accumulator.
    always_comb begin : mac
        logic signed [PW-1:0] prod;
        prod = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
                prod           = a_r[i][idx] * b_r[idx][j];
                acc_next[i][j] = acc[i][j] + {{(ACCW - PW){prod[PW-1]}}, prod};
            end
        end
    end

    function automatic logic signed [DATAWIDTH-1:0] convert(input logic signed [ACCW-1:0] a);
        logic signed [ACCW-1:0] r;
        r = (a + RND) >>> FRACBITS;
`ifdef MAT_MUL_SAT_EN
        if (r > SAT_MAX)
            return SAT_MAX[DATAWIDTH-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[DATAWIDTH-1:0];
        else
            return r[DATAWIDTH-1:0];
`else
        return r[DATAWIDTH-1:0];
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_dv    <= 1'b0;
            idx     <= '0;
            // NOTE: the operand, accumulator and result arrays are reset explicitly so an abort leaves no stale data visible.
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++) begin
                    acc[i][j] <= '0;
                    C[i][j]   <= '0;
                end
            for (int i = 0; i < M; i++)
                for (int k = 0; k < K; k++)
                    a_r[i][k] <= '0;
            for (int k = 0; k < K; k++)
                for (int j = 0; j < N; j++)
                    b_r[k][j] <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
            case (state)
                IDLE: begin
                    if (i_dv) begin
                        a_r     <= A;
                        b_r     <= B;
                        idx     <= '0;
                        o_ready <= 1'b0;
                        state   <= ACCUM;
                        for (int i = 0; i < M; i++)
                            for (int j = 0; j < N; j++)
                                acc[i][j] <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        for (int i = 0; i < M; i++)
                            for (int j = 0; j < N; j++)
                                C[i][j] <= convert(acc_next[i][j]);
                        o_dv  <= 1'b1;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_dv    <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_dv    <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mat_mul_mnk.sv
// Scoreboard bench for mat_mul_mnk: default 4x4x4 instance plus a 2x3x1 instance.
module tb_mat_mul_mnk;

    localparam int DW = 18;
    localparam int FB = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic signed [DW-1:0] a [4][4];
    logic signed [DW-1:0] b [4][4];
    logic signed [DW-1:0] c [4][4];
    logic i_dv, o_ready, o_dv, i_ready;

    logic signed [DW-1:0] a2 [2][3];
    logic signed [DW-1:0] b2 [3][1];
    logic signed [DW-1:0] c2 [2][1];
    logic i_dv2, o_ready2, o_dv2, i_ready2;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];
    longint last_exp00;

    mat_mul_mnk u_dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .i_dv(i_dv), .o_ready(o_ready),
        .C(c), .o_dv(o_dv), .i_ready(i_ready)
    );

    mat_mul_mnk #(.M(2), .K(3), .N(1)) u_dut_ns (
        .clk(clk), .rst(rst), .A(a2), .B(b2), .i_dv(i_dv2), .o_ready(o_ready2),
        .C(c2), .o_dv(o_dv2), .i_ready(i_ready2)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input longint exp);
        checks++;
        if (got !== 64'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference conversion: round half up, shift, then saturate or wrap to DW bits.
    function automatic longint conv(input longint acc);
        longint r;
        r = (acc + (longint'(1) << (FB - 1))) >>> FB;
`ifdef MAT_MUL_SAT_EN
        if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
        if (r < -(longint'(1) << (DW - 1)))    r = -(longint'(1) << (DW - 1));
`else
        r = r & ((longint'(1) << DW) - 1);
        if (r >= (longint'(1) << (DW - 1))) r = r - (longint'(1) << DW);
`endif
        return r;
    endfunction

    task automatic push_expected();
        longint acc;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc += longint'(a[i][k]) * longint'(b[k][j]);
                exp_q.push_back(conv(acc));
            end
    endtask

    task automatic clear_ab();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a[i][j] = '0;
                b[i][j] = '0;
            end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a[i][j] = (i == j) ? 18'sd4096 : 18'sd0;
                b[i][j] = DW'(4096 * (i * 4 + j) - 30000);
            end
    endtask

    task automatic compare_out(input string tag);
        longint e;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_sb_empty"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (i == 0 && j == 0) last_exp00 = e;
                    check($sformatf("%s_c%0d%0d", tag, i, j), c[i][j], e);
                end
            end
    endtask

    // Called #1 after a posedge with the DUT idle; ends #1 after the edge where o_dv rose.
    task automatic drive_and_wait(input string tag);
        int cyc;
        check({tag, "_rdy"}, o_ready, 1);
        i_dv = 1'b1;
        push_expected();
        @(posedge clk); #1;
        i_dv = 1'b0;
        check({tag, "_busy"}, o_ready, 0);
        cyc = 0;
        while (!o_dv && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 4);
        compare_out(tag);
    endtask

    task automatic release_out(input string tag);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        check({tag, "_dv_low"}, o_dv, 0);
        check({tag, "_rdy_hi"}, o_ready, 1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        i_dv = 1'b0; i_ready = 1'b0; i_dv2 = 1'b0; i_ready2 = 1'b0;
        clear_ab();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 3; k++)
                a2[i][k] = '0;
        for (int k = 0; k < 3; k++)
            b2[k][0] = '0;
        #12;
        check("reset_rdy", o_ready, 1);
        check("reset_dv", o_dv, 0);
        check("reset_c00", c[0][0], 0);
        check("reset_c33", c[3][3], 0);
        check("reset_ns_rdy", o_ready2, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity
        set_identity();
        drive_and_wait("ident");
        release_out("ident");

        // Rounding, positive then negative
        clear_ab();
        a[0][0] = 18'sd1; b[0][0] = 18'sd2048;
        drive_and_wait("round_pos");
        check("round_pos_const", c[0][0], 1);
        release_out("round_pos");
        a[0][0] = -18'sd1;
        drive_and_wait("round_neg");
        check("round_neg_const", c[0][0], 0);
        release_out("round_neg");

        // Overflow
        clear_ab();
        a[0][0] = 18'sd81920; b[0][0] = 18'sd81920;
        drive_and_wait("ovf");
`ifdef MAT_MUL_SAT_EN
        check("ovf_const", c[0][0], 131071);
`else
        check("ovf_const", c[0][0], 65536);
`endif
        release_out("ovf");

        // Random operands followed by backpressure with ignored inputs
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a[i][j] = DW'($urandom);
                b[i][j] = DW'($urandom);
            end
        drive_and_wait("rand");
        for (int n = 0; n < 5; n++) begin
            a[0][0] = DW'($urandom);
            b[0][0] = DW'($urandom);
            i_dv = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_dv_%0d", n), o_dv, 1);
            check($sformatf("bp_rdy_%0d", n), o_ready, 0);
            check($sformatf("bp_c00_%0d", n), c[0][0], last_exp00);
        end
        i_dv = 1'b0;
        release_out("bp");
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            check($sformatf("bp_idle_dv_%0d", n), o_dv, 0);
            check($sformatf("bp_idle_rdy_%0d", n), o_ready, 1);
        end

        // Reset two cycles into ACCUM, then a fresh identity run
        set_identity();
        check("abort_rdy", o_ready, 1);
        i_dv = 1'b1;
        push_expected();
        @(posedge clk); #1;
        i_dv = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_dv", o_dv, 0);
        check("abort_rdy_hi", o_ready, 1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                check($sformatf("abort_c%0d%0d", i, j), c[i][j], 0);
        repeat (16) void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive_and_wait("ident2");
        release_out("ident2");

        // Non-square 2x3x1
        a2[0][0] = 18'sd4096;  a2[0][1] = 18'sd8192; a2[0][2] = 18'sd12288;
        a2[1][0] = -18'sd4096; a2[1][1] = 18'sd2048; a2[1][2] = 18'sd1024;
        for (int k = 0; k < 3; k++) b2[k][0] = 18'sd4096;
        check("ns_rdy", o_ready2, 1);
        i_dv2 = 1'b1;
        exp_q.push_back(24576);
        exp_q.push_back(-1024);
        @(posedge clk); #1;
        i_dv2 = 1'b0;
        check("ns_busy", o_ready2, 0);
        cyc = 0;
        while (!o_dv2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ns_lat", cyc, 3);
        for (int i = 0; i < 2; i++) begin
            if (exp_q.size() == 0) check("ns_sb_empty", 1, 0);
            else check($sformatf("ns_c%0d", i), c2[i][0], exp_q.pop_front());
        end
        i_ready2 = 1'b1;
        @(posedge clk); #1;
        i_ready2 = 1'b0;
        check("ns_dv_low", o_dv2, 0);
        check("ns_rdy_hi", o_ready2, 1);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
